// File: rtl/hub_pkg.sv
// Shared definitions for the nonce uplink arbiter.
// Contents: nonce/drop-counter widths, handshake FSM state type, index-width helper.
package hub_pkg;

  localparam int NONCE_W = 32;
  localparam int DROP_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  // Width needed to index n sources (never below 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nonce_uplink_arbiter_if.sv
// Bus between the nonce sources / serial transmitter and the uplink arbiter.
// master: drives slave_nonces, new_nonces, slave_enable, serial_busy;
//         observes serial_send, golden_nonce, golden_src, pending, drop_count.
// slave : the arbiter side (directions reversed).
interface nonce_uplink_arbiter_if import hub_pkg::*; #(
  parameter int SLAVES = 4
) ();

  localparam int IDX_W = idx_width(SLAVES);

  logic [SLAVES*NONCE_W-1:0] slave_nonces;
  logic [SLAVES-1:0]         new_nonces;
  logic [SLAVES-1:0]         slave_enable;
  logic                      serial_busy;
  logic                      serial_send;
  logic [NONCE_W-1:0]        golden_nonce;
  logic [IDX_W-1:0]          golden_src;
  logic [SLAVES-1:0]         pending;
  logic [DROP_W-1:0]         drop_count;

  modport master (
    output slave_nonces, new_nonces, slave_enable, serial_busy,
    input  serial_send, golden_nonce, golden_src, pending, drop_count
  );

  modport slave (
    input  slave_nonces, new_nonces, slave_enable, serial_busy,
    output serial_send, golden_nonce, golden_src, pending, drop_count
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin find-first-set.
// Ports: req   - request vector
//        ptr   - index of the last winner; the search starts at ptr+1
//        valid - at least one request is set
//        index - first set request at or after ptr+1, wrapping to 0
module rr_pick import hub_pkg::*; #(
  parameter  int SLAVES = 4,
  localparam int IDX_W  = idx_width(SLAVES)
) (
  input  logic [SLAVES-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              valid,
  output logic [IDX_W-1:0]  index
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    // Offsets 1..SLAVES visit every source once, the last one being ptr itself.
    for (int unsigned k = 1; k <= SLAVES; k++) begin
      cand = IDX_W'((32'(ptr) + k) % SLAVES);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/nonce_uplink_arbiter.sv
// Shares one serial_transmit uplink between SLAVES nonce sources.
// Each source's new_nonce strobe is captured into a one-deep holding slot;
// full slots are granted round-robin and sent with a send/busy handshake.
// Ports: clk, rst_n (async, active low)
//        bus.slave  - nonces/strobes/enables and serial_busy in;
//                     serial_send, golden_nonce, golden_src, pending,
//                     drop_count out.
module nonce_uplink_arbiter import hub_pkg::*; #(
  parameter int SLAVES       = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  nonce_uplink_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(SLAVES);
  localparam int TO_W  = $clog2(BUSY_TIMEOUT) + 1;

  state_t              state;
  logic [NONCE_W-1:0]  slot [SLAVES];
  logic [SLAVES-1:0]   pending;
  logic [IDX_W-1:0]    rr_ptr;
  logic [TO_W-1:0]     to_cnt;
  logic                send;
  logic [NONCE_W-1:0]  golden_nonce;
  logic [IDX_W-1:0]    golden_src;
  logic [DROP_W-1:0]   drop_count;

  logic                win_valid;
  logic [IDX_W-1:0]    win_idx;
  logic                grant;
  logic [SLAVES-1:0]   capture;
  logic [SLAVES-1:0]   granted;
  logic [SLAVES-1:0]   drop;
  int unsigned         n_drop;
  logic [DROP_W:0]     drop_sum;
  logic [DROP_W-1:0]   drop_next;

  rr_pick #(.SLAVES(SLAVES)) u_pick (
    .req   (pending),
    .ptr   (rr_ptr),
    .valid (win_valid),
    .index (win_idx)
  );

  assign grant = (state == ST_IDLE) && win_valid && !bus.serial_busy;

  always_comb begin
    capture = bus.new_nonces & bus.slave_enable;
    granted = '0;
    if (grant) granted[win_idx] = 1'b1;
    // A slot being granted this cycle frees up in time to take the new nonce.
    drop   = capture & pending & ~granted;
    n_drop = 0;
    for (int unsigned i = 0; i < SLAVES; i++) n_drop += 32'(drop[i]);
    drop_sum  = {1'b0, drop_count} + (DROP_W+1)'(n_drop);
    drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  // Holding slots and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      drop_count <= '0;
      for (int unsigned i = 0; i < SLAVES; i++) slot[i] <= '0;
    end else begin
      drop_count <= drop_next;
      for (int unsigned i = 0; i < SLAVES; i++) begin
        if (capture[i] && (!pending[i] || granted[i])) begin
          slot[i]    <= bus.slave_nonces[i*NONCE_W +: NONCE_W];
          pending[i] <= 1'b1;
        end else if (granted[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Grant and transmitter handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      send         <= 1'b0;
      golden_nonce <= '0;
      golden_src   <= '0;
      rr_ptr       <= IDX_W'(SLAVES - 1);
      to_cnt       <= '0;
    end else begin
      send <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            golden_nonce <= slot[win_idx];
            golden_src   <= win_idx;
            rr_ptr       <= win_idx;
            send         <= 1'b1;
            state        <= ST_SEND;
          end
        end
        ST_SEND: begin
          to_cnt <= '0;
          state  <= bus.serial_busy ? ST_WAIT_DONE : ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // Transmitter never acknowledged: give up, the word is not retried.
          if (bus.serial_busy) begin
            state <= ST_WAIT_DONE;
          end else if (to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
            state <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.serial_busy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.serial_send  = send;
  assign bus.golden_nonce = golden_nonce;
  assign bus.golden_src   = golden_src;
  assign bus.pending      = pending;
  assign bus.drop_count   = drop_count;

endmodule

// File: tb/tb_nonce_uplink_arbiter.sv
// Scoreboard bench for nonce_uplink_arbiter (SLAVES=4, BUSY_TIMEOUT=4).
// The stimulus process drives inputs just after each rising edge and steps a
// behavioural model of the slots, pushing each predicted transmission (word,
// source, edge number) into a queue; a monitor pops and compares on every
// serial_send pulse seen at the falling edge.
module tb_nonce_uplink_arbiter;
  import hub_pkg::*;

  localparam int S  = 4;
  localparam int TO = 4;
  localparam int IW = idx_width(S);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  nonce_uplink_arbiter_if #(.SLAVES(S)) bus ();

  nonce_uplink_arbiter #(.SLAVES(S), .BUSY_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  int unsigned edges = 0;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at edge %0d", name, edges);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [31:0] nonce;
    int          src;
    int unsigned at;
  } xfer_t;

  xfer_t       expq[$];
  xfer_t       sent_log[$];
  bit          m_full[S];
  logic [31:0] m_val[S];
  int          m_rr;
  int          m_drop;
  bit          m_xfer;   // a word is on its way to the transmitter
  bit          m_seen;   // transmitter has raised busy for it
  int          m_since;  // edges since the grant

  function automatic void model_reset();
    for (int i = 0; i < S; i++) begin
      m_full[i] = 0;
      m_val[i]  = '0;
    end
    m_rr = S - 1; m_drop = 0; m_xfer = 0; m_seen = 0; m_since = 0;
  endfunction

  // Effect of one rising edge given the inputs present at that edge.
  function automatic void model_step(input logic [S-1:0] stb, input logic [S*32-1:0] nv,
                                     input logic [S-1:0] en, input logic busy);
    int win = -1;
    bit was_xfer = m_xfer;
    if (!m_xfer && !busy) begin
      for (int k = 1; k <= S; k++) begin
        int j = (m_rr + k) % S;
        if (win < 0 && m_full[j]) win = j;
      end
    end
    if (win >= 0) begin
      expq.push_back('{m_val[win], win, edges + 1});
      m_rr = win; m_full[win] = 0;
      m_xfer = 1; m_since = 0; m_seen = 0;
    end
    for (int i = 0; i < S; i++) begin
      if (stb[i] && en[i]) begin
        if (!m_full[i]) begin
          m_full[i] = 1;
          m_val[i]  = nv[i*32 +: 32];
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
    end
    if (was_xfer) begin
      m_since++;
      if (m_since == 1)       m_seen = busy;
      else if (m_seen)        begin if (!busy) m_xfer = 0; end
      else if (busy)          m_seen = 1;
      else if (m_since - 1 >= TO) m_xfer = 0;
    end
  endfunction

  function automatic logic [S-1:0] model_pending();
    logic [S-1:0] p;
    for (int i = 0; i < S; i++) p[i] = m_full[i];
    return p;
  endfunction

  // ---------------- transmitter busy model ----------------
  int   bmode = 0;   // 0: react to send, 1: never busy, 2: stuck busy
  int   bdelay = 1;
  int   blen = 20;
  int   pend_d = 0;
  int   busy_left = 0;
  logic [S-1:0] en_cur = '1;

  // Drive inputs for the coming edge (called just after an edge), step the model.
  task automatic cycle(input logic [S-1:0] stb, input logic [S*32-1:0] nv, input logic [S-1:0] en);
    logic busy;
    if (bus.serial_send && bmode == 0) pend_d = bdelay + 1;
    if (pend_d > 0) begin
      pend_d--;
      if (pend_d == 0) busy_left = blen;
    end
    if (bmode == 2)      busy = 1'b1;
    else if (bmode == 1) busy = 1'b0;
    else begin
      busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
    bus.serial_busy  = busy;
    bus.new_nonces   = stb;
    bus.slave_nonces = nv;
    bus.slave_enable = en;
    model_step(stb, nv, en, busy);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle('0, '0, en_cur);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_pending"}, 64'(bus.pending), 64'(model_pending()));
    chk({tag, "_drops"}, 64'(bus.drop_count), 64'(m_drop));
  endtask

  task automatic do_reset(input bit check_now);
    rst_n = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_send",   64'(bus.serial_send),  64'd0);
      chk("rst_nonce",  64'(bus.golden_nonce), 64'd0);
      chk("rst_src",    64'(bus.golden_src),   64'd0);
      chk("rst_pending",64'(bus.pending),      64'd0);
      chk("rst_drops",  64'(bus.drop_count),   64'd0);
    end
    model_reset();
    expq.delete();
    sent_log.delete();
    pend_d = 0; busy_left = 0;
    bus.serial_busy = 1'b0; bus.new_nonces = '0; bus.slave_nonces = '0; bus.slave_enable = en_cur;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic prev_send = 1'b0;
    xfer_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_send = 1'b0;
      end else begin
        if (bus.serial_send) begin
          chk("send_back_to_back", 64'(prev_send), 64'd0);
          if (expq.size() > 0 && expq[0].at == edges) begin
            e = expq.pop_front();
            chk("golden_nonce", 64'(bus.golden_nonce), 64'(e.nonce));
            chk("golden_src",   64'(bus.golden_src),   64'(e.src));
            sent_log.push_back('{bus.golden_nonce, int'(bus.golden_src), edges});
          end else begin
            fail("unexpected_send");
          end
        end
        while (expq.size() > 0 && expq[0].at <= edges) begin
          fail("missing_send");
          void'(expq.pop_front());
        end
        prev_send = bus.serial_send;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [S*32-1:0] nv;
    int unsigned cap_edge;
    bit found;
    bus.serial_busy = 1'b0; bus.new_nonces = '0; bus.slave_nonces = '0; bus.slave_enable = '1;
    model_reset();

    #2 do_reset(1'b1);

    // Single source: latency 2 cycles from strobe to send.
    bmode = 0; bdelay = 1; blen = 20;
    idle(8);
    nv = '0; nv[2*32 +: 32] = 32'hDEADBEEF;
    cap_edge = edges + 1;
    cycle(4'b0100, nv, en_cur);
    idle(30);
    check_state("single");
    chk("single_count", 64'(sent_log.size()), 64'd1);
    if (sent_log.size() == 1) begin
      chk("single_latency", 64'(sent_log[0].at), 64'(cap_edge + 1));
      chk("single_src", 64'(sent_log[0].src), 64'd2);
    end
    chk("single_nonce_hold", 64'(bus.golden_nonce), 64'hDEADBEEF);

    // Fairness from reset pointer.
    do_reset(1'b0);
    bdelay = 1; blen = 5;
    for (int i = 0; i < S; i++) nv[i*32 +: 32] = 32'h100 + i;
    cycle(4'b1111, nv, en_cur);
    idle(60);
    chk("fair_count", 64'(sent_log.size()), 64'd4);
    for (int i = 0; i < S && i < sent_log.size(); i++) begin
      chk("fair_order", 64'(sent_log[i].src), 64'(i));
      chk("fair_value", 64'(sent_log[i].nonce), 64'(32'h100 + i));
    end
    sent_log.delete();
    cycle(4'b1010, nv, en_cur);
    idle(40);
    chk("fair2_count", 64'(sent_log.size()), 64'd2);
    if (sent_log.size() == 2) begin
      chk("fair2_first", 64'(sent_log[0].src), 64'd1);
      chk("fair2_second", 64'(sent_log[1].src), 64'd3);
    end

    // Overflow while the transmitter is busy.
    do_reset(1'b0);
    bmode = 2;
    nv = '0; nv[31:0] = 32'hA; cycle(4'b0001, nv, en_cur);
    nv[31:0] = 32'hB;          cycle(4'b0001, nv, en_cur);
    nv[31:0] = 32'hC;          cycle(4'b0001, nv, en_cur);
    idle(3);
    check_state("ovf");
    chk("ovf_drops", 64'(bus.drop_count), 64'd2);
    bmode = 0; bdelay = 1; blen = 4;
    idle(30);
    chk("ovf_sent", 64'(bus.golden_nonce), 64'hA);

    // Grant collision on slave 1.
    do_reset(1'b0);
    nv = '0; nv[1*32 +: 32] = 32'h10; cycle(4'b0010, nv, en_cur);
    nv[1*32 +: 32] = 32'h11;          cycle(4'b0010, nv, en_cur);
    idle(40);
    chk("coll_count", 64'(sent_log.size()), 64'd2);
    if (sent_log.size() == 2) begin
      chk("coll_first", 64'(sent_log[0].nonce), 64'h10);
      chk("coll_second", 64'(sent_log[1].nonce), 64'h11);
    end
    chk("coll_drops", 64'(bus.drop_count), 64'd0);

    // Busy never rises: handshake times out, next word still goes.
    do_reset(1'b0);
    bmode = 1;
    nv = '0; nv[31:0] = 32'h50; nv[3*32 +: 32] = 32'h53;
    cycle(4'b1001, nv, en_cur);
    idle(30);
    chk("to_count", 64'(sent_log.size()), 64'd2);
    if (sent_log.size() == 2) begin
      chk("to_spacing", 64'(sent_log[1].at - sent_log[0].at), 64'd6);
      chk("to_second_src", 64'(sent_log[1].src), 64'd3);
    end

    // Reset during WAIT_DONE with another word still pending.
    do_reset(1'b0);
    bmode = 0; bdelay = 0; blen = 20;
    nv = '0; nv[1*32 +: 32] = 32'h61; nv[2*32 +: 32] = 32'h62;
    cycle(4'b0110, nv, en_cur);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle('0, '0, en_cur);
      if (m_xfer && m_seen && bus.serial_busy) found = 1;
    end
    if (!found) fail("reach_wait_done");
    chk("mid_pending_before", 64'(bus.pending), 64'(model_pending()));
    do_reset(1'b1);
    idle(30);
    chk("mid_no_resend", 64'(sent_log.size()), 64'd0);

    // Enable mask: slave 2 ignored.
    en_cur = 4'b1011;
    nv = '0; nv[2*32 +: 32] = 32'h77;
    cycle(4'b0100, nv, en_cur);
    idle(5);
    check_state("mask");
    chk("mask_pending", 64'(bus.pending), 64'd0);
    en_cur = '1;

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [S-1:0] stb;
      if (n % 150 == 0) begin
        bmode  = ($urandom_range(0, 5) == 0) ? 1 : 0;
        bdelay = $urandom_range(0, 2);
        blen   = $urandom_range(1, 8);
        en_cur = ($urandom_range(0, 3) == 0) ? S'($urandom) : '1;
      end
      for (int i = 0; i < S; i++) nv[i*32 +: 32] = $urandom;
      stb = ($urandom_range(0, 2) == 0) ? S'($urandom) : '0;
      cycle(stb, nv, en_cur);
      if (n % 10 == 0) check_state("rand");
    end
    bmode = 0; en_cur = '1;
    idle(150);
    check_state("drain");
    chk("drain_queue", 64'(expq.size()), 64'd0);

    // Drop counter saturation.
    do_reset(1'b0);
    bmode = 2;
    for (int n = 0; n < 16400; n++) begin
      for (int i = 0; i < S; i++) nv[i*32 +: 32] = $urandom;
      cycle('1, nv, '1);
    end
    check_state("sat");
    chk("sat_value", 64'(bus.drop_count), 64'hFFFF);
    cycle('1, nv, '1);
    chk("sat_hold", 64'(bus.drop_count), 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
